uart_instr_server: RTL and testbench
====================================

# uart_instr_server

Host-side instruction responder for the Bitty fetch path. It sits on the external end of the UART link and answers the core's fetch requests. Each received address byte is looked up in a local 256×16 instruction memory. The 16-bit word goes back as two UART bytes, high byte first. The block drives a standard `uart_module` instance through its byte-level rx/tx handshake. It gives benches and the companion FPGA a self-contained program source for the core.

## Interface
Parameters:
- `ADDR_W`, 8: address byte width; memory depth is 2^ADDR_W.
- `DATA_W`, 16: instruction width; always sent as two bytes.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-low.
- `rx_done`  in  1  one-cycle pulse from the UART; `rx_data` is valid in that cycle.
- `rx_data`  in  8  received byte (request address).
- `tx_done`  in  1  one-cycle pulse from the UART when the current byte has finished transmitting.
- `tx_en`  out  1  one-cycle start pulse to the UART transmitter.
- `tx_data`  out  8  byte to transmit; held stable from the `tx_en` cycle until `tx_done`.
- `wr_en`  in  1  memory load strobe from the program loader.
- `wr_addr`  in  8  load address.
- `wr_data`  in  16  load data.
- `busy`  out  1  high from the cycle after the request is accepted until the response completes.
- `overrun`  out  1  sticky flag: a request byte arrived while `busy`.
- `req_count`  out  8  number of completed responses, modulo 256.

## Operation
- States: IDLE, LOOKUP, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO.
- IDLE: when `rx_done` is high, latch `rx_data` as the address and go to LOOKUP.
- LOOKUP: read `mem[addr]` into a 16-bit response register, then go to SEND_HI.
- SEND_HI: `tx_data` = resp[15:8] and `tx_en` = 1 for exactly one cycle, then go to WAIT_HI.
- WAIT_HI: on `tx_done`, go to SEND_LO.
- SEND_LO: `tx_data` = resp[7:0] and `tx_en` = 1 for one cycle, then go to WAIT_LO.
- WAIT_LO: on `tx_done`, increment `req_count` (wraps 255→0) and go to IDLE.
- `rx_done` in any state other than IDLE: the byte is dropped and `overrun` is set. The flag clears only on reset.
- `tx_done` outside WAIT_HI/WAIT_LO is ignored.
- Memory writes:
  - A write with `wr_en` high is accepted in any cycle and is visible from the next cycle.
  - A write to the same address in the LOOKUP cycle returns the old data (read-before-write).
- Reset:
  - Returns the FSM to IDLE from any state, including mid-response.
  - Outputs on reset: `tx_en`=0, `tx_data`=0x00, `busy`=0, `overrun`=0, `req_count`=0.
  - Memory contents are not reset; they persist across reset.

## Timing
- Request latency: `rx_done` at cycle N → LOOKUP at N+1 → first `tx_en` at N+2.
- Byte spacing: `tx_done` for the high byte at cycle M → second `tx_en` at M+1.
- Completion: `tx_done` for the low byte at cycle K → IDLE at K+1, with `req_count` already updated. A new request is accepted at K+1.
- `busy` = 1 in every state except IDLE.
- Back-to-back requests: a `rx_done` in the same cycle the FSM re-enters IDLE is accepted. A `rx_done` in cycle K itself (WAIT_LO) is an overrun.
- `tx_data` is registered and holds its last value in IDLE.

## Structure
- Shared package `bitty_uart_pkg`:
  - state enum / localparams for the six states.
  - `RESP_BYTES` = 2.
  - `ADDR_W` / `DATA_W` defaults.
- Sub-module `instr_mem`:
  - 2^ADDR_W × DATA_W register array.
  - Synchronous write port, registered read port, no reset.
- The FSM and counters stay in `uart_instr_server`.

## Test plan
- Load mem[0x05]=0xA1B2, then send request 0x05 → `tx_en` at N+2 with 0xA1. After `tx_done`, `tx_en` next cycle with 0xB2. `req_count`=1.
- Request 0x05, then send 0x06 while in WAIT_HI → response is 0xA1, 0xB2 only. `overrun`=1; `req_count`=1.
- Write mem[0x10]=0x1234 in the LOOKUP cycle of request 0x10, where mem[0x10] held 0xFFFF → bytes sent are 0xFF, 0xFF. A following request 0x10 returns 0x12, 0x34.
- Assert reset during WAIT_LO → next cycle IDLE, `tx_en`=0, `busy`=0, `req_count`=0. A re-request returns the loaded data, proving memory survived reset.
- Run 256 consecutive requests to 0x00..0xFF → `req_count` wraps to 0x00. Every byte pair matches the loaded pattern.
- Pulse `tx_done` spuriously in IDLE → no state change and no `tx_en`.

Source files
------------

// File: rtl/bitty_uart_pkg.sv
// bitty_uart_pkg: shared states and sizing for the Bitty UART instruction server.
package bitty_uart_pkg;
  localparam int RESP_BYTES = 2;
  localparam int DEFAULT_ADDR_W = 8;
  localparam int DEFAULT_DATA_W = 8 * RESP_BYTES;
  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    SEND_HI,
    WAIT_HI,
    SEND_LO,
    WAIT_LO
  } state_e;
endpackage

// File: rtl/instr_mem.sv
// instr_mem: instruction store with a synchronous write port and an enabled registered read port.
module instr_mem
  import bitty_uart_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data_q
);
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  // A write in the read cycle is forwarded so it is visible on the following cycle.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= (wr_en && wr_addr == rd_addr) ? wr_data : mem_q[rd_addr];
  end
endmodule

// File: rtl/uart_instr_server.sv
// uart_instr_server: answers UART address bytes with the 16-bit instruction word, high byte first.
module uart_instr_server
  import bitty_uart_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_done,
  input  logic [7:0]        rx_data,
  input  logic              tx_done,
  output logic              tx_en,
  output logic [7:0]        tx_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              overrun,
  output logic [7:0]        req_count
);
  state_e            state_q, state_d;
  logic              tx_en_q, tx_en_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic [7:0]        req_count_q, req_count_d;
  logic [DATA_W-1:0] resp;
  logic              rd_en;

  // The address is sampled straight off rx_data; the read result then stays frozen as the response.
  assign rd_en = (state_q == IDLE) && rx_done;

  instr_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
    .clk      (clk),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rx_data[ADDR_W-1:0]),
    .rd_data_q(resp)
  );

  always_comb begin
    state_d     = state_q;
    tx_en_d     = 1'b0;
    tx_data_d   = tx_data_q;
    req_count_d = req_count_q;
    overrun_d   = overrun_q | (rx_done && state_q != IDLE);
    unique case (state_q)
      IDLE:    state_d = rx_done ? LOOKUP : IDLE;
      LOOKUP: begin
        state_d   = SEND_HI;
        tx_en_d   = 1'b1;
        tx_data_d = resp[DATA_W-1 -: 8];
      end
      SEND_HI: state_d = WAIT_HI;
      WAIT_HI: if (tx_done) begin
        state_d   = SEND_LO;
        tx_en_d   = 1'b1;
        tx_data_d = resp[7:0];
      end
      SEND_LO: state_d = WAIT_LO;
      WAIT_LO: if (tx_done) begin
        state_d     = IDLE;
        req_count_d = req_count_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      tx_en_q     <= 1'b0;
      tx_data_q   <= 8'h00;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      req_count_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      tx_en_q     <= tx_en_d;
      tx_data_q   <= tx_data_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      req_count_q <= req_count_d;
    end
  end

  assign tx_en     = tx_en_q;
  assign tx_data   = tx_data_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;
  assign req_count = req_count_q;
endmodule

// File: tb/tb_uart_instr_server.sv
// tb_uart_instr_server: randomized request/response checks against a memory-and-counter model.
module tb_uart_instr_server;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_done = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_done = 1'b0;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_addr = 8'h00;
  logic [15:0] wr_data = 16'h0000;
  logic        busy;
  logic        overrun;
  logic [7:0]  req_count;

  logic [15:0] mem_m [256];
  logic [7:0]  cnt_m;
  logic        ovr_m;
  int          checks = 0;
  int          failures = 0;

  uart_instr_server dut (
    .clk      (clk),
    .reset    (reset),
    .rx_done  (rx_done),
    .rx_data  (rx_data),
    .tx_done  (tx_done),
    .tx_en    (tx_en),
    .tx_data  (tx_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .overrun  (overrun),
    .req_count(req_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    repeat (n) cyc();
    reset = 1'b1;
    cnt_m = 8'h00;
    ovr_m = 1'b0;
    chk("rst_tx_en", tx_en, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_req_count", req_count, 0);
  endtask

  task automatic mem_write(input logic [7:0] a, input logic [15:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    cyc();
    wr_en = 1'b0;
    mem_m[a] = d;
  endtask

  // mode: 0 plain, 1 stray byte while waiting on the high byte, 2 stray byte with the final tx_done,
  // 3 overwrite the address during lookup, 4 reset while waiting on the low byte
  task automatic request(input logic [7:0] a, input int mode, input logic [15:0] wd);
    logic [15:0] w;
    w = mem_m[a];
    rx_done = 1'b1;
    rx_data = a;
    cyc();
    rx_done = 1'b0;
    chk("lookup_busy", busy, 1);
    chk("lookup_tx_en", tx_en, 0);
    if (mode == 3) begin
      wr_en = 1'b1;
      wr_addr = a;
      wr_data = wd;
    end
    cyc();
    wr_en = 1'b0;
    if (mode == 3) mem_m[a] = wd;
    chk("hi_tx_en", tx_en, 1);
    chk("hi_tx_data", tx_data, w[15:8]);
    repeat (1 + $urandom_range(2)) begin
      if (mode == 1) begin
        rx_done = 1'b1;
        rx_data = a + 8'd1;
      end
      cyc();
      rx_done = 1'b0;
      chk("wait_hi_tx_en", tx_en, 0);
      chk("wait_hi_tx_data", tx_data, w[15:8]);
    end
    tx_done = 1'b1;
    cyc();
    tx_done = 1'b0;
    chk("lo_tx_en", tx_en, 1);
    chk("lo_tx_data", tx_data, w[7:0]);
    cyc();
    chk("wait_lo_tx_en", tx_en, 0);
    chk("wait_lo_busy", busy, 1);
    if (mode == 4) begin
      do_reset(1);
      return;
    end
    repeat ($urandom_range(2)) begin
      cyc();
      chk("wait_lo_hold", tx_data, w[7:0]);
    end
    tx_done = 1'b1;
    if (mode == 2) begin
      rx_done = 1'b1;
      rx_data = a;
    end
    cyc();
    tx_done = 1'b0;
    rx_done = 1'b0;
    cnt_m = cnt_m + 8'd1;
    if (mode == 1 || mode == 2) ovr_m = 1'b1;
    chk("done_busy", busy, 0);
    chk("done_tx_en", tx_en, 0);
    chk("done_tx_data", tx_data, w[7:0]);
    chk("done_req_count", req_count, cnt_m);
    chk("done_overrun", overrun, ovr_m);
    if (mode == 1 || mode == 2) begin
      cyc();
      chk("dropped_busy", busy, 0);
      cyc();
      chk("dropped_tx_en", tx_en, 0);
    end
  endtask

  initial begin
    do_reset(3);
    for (int i = 0; i < 256; i++) mem_write(i[7:0], 16'($urandom));
    mem_write(8'h05, 16'hA1B2);
    mem_write(8'h10, 16'hFFFF);
    tx_done = 1'b1;
    cyc();
    tx_done = 1'b0;
    chk("spurious_tx_en", tx_en, 0);
    chk("spurious_busy", busy, 0);
    cyc();
    chk("spurious_tx_en2", tx_en, 0);
    chk("spurious_busy2", busy, 0);
    request(8'h05, 0, 16'h0);
    request(8'h05, 1, 16'h0);
    request(8'h10, 3, 16'h1234);
    request(8'h10, 0, 16'h0);
    request(8'h05, 4, 16'h0);
    cyc();
    chk("post_rst_busy", busy, 0);
    request(8'h05, 0, 16'h0);
    request(8'($urandom), 2, 16'h0);
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(1) == 1) mem_write(8'($urandom), 16'($urandom));
      request(8'($urandom), 0, 16'h0);
    end
    do_reset(2);
    for (int i = 0; i < 256; i++) request(i[7:0], 0, 16'h0);
    chk("wrap_req_count", req_count, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
